gray_display_mux: RTL and testbench

Parametrised multi-digit seven-segment display driver for the Gray-code decoder path. It accepts an IN_WIDTH-bit Gray code on a load strobe, converts it to binary, then to BCD with a sequential shift-add-3 engine, and latches the resulting digits. It then time-multiplexes them onto a common-cathode bus with one active-low anode per digit. This block replaces the fixed single-pattern cathode decoder: it adds an arbitrary input width, arbitrary digit count, refresh scanning and optional leading-zero blanking.

---
 rtl/display_pkg.sv | 56 +++++
 rtl/bin_a_bcd.sv | 80 ++++++++
 rtl/gray_display_mux.sv | 115 +++++++++++
 tb/tb_gray_display_mux.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types, segment patterns and helpers for the Gray-code seven-segment display path.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    // Each binary bit is the XOR of its Gray bit and every more significant Gray bit.
    function automatic logic [31:0] gray_to_bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // True when nd decimal digits can hold the largest in_w-bit value.
    function automatic bit digits_fit(input int unsigned in_w, input int unsigned nd);
        longint unsigned limit;
        longint unsigned max_val;
        limit = 64'd1;
        for (int unsigned i = 0; i < nd; i++) begin
            if (limit < 64'h2_0000_0000) limit = limit * 64'd10;
        end
        max_val = (64'd1 << in_w) - 64'd1;
        return (in_w >= 2) && (in_w <= 32) && (limit > max_val);
    endfunction

endpackage

// File: rtl/bin_a_bcd.sv
// Sequential shift-add-3 binary to BCD converter; one shift per cycle.
module bin_a_bcd
    import display_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = 4,
    parameter int unsigned NUM_DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [IN_WIDTH-1:0]       bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [4*NUM_DIGITS-1:0]   bcd_out
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(IN_WIDTH + 1);

    conv_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IN_WIDTH-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   adj_c;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        adj_c   = bcd_q;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) adj_c[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin_in;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(IN_WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {adj_c, bin_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;

endmodule

// File: rtl/gray_display_mux.sv
// Gray input to multiplexed common-cathode seven-segment display with leading-zero blanking.
module gray_display_mux
    import display_pkg::*;
#(
    parameter int unsigned IN_WIDTH      = 4,
    parameter int unsigned NUM_DIGITS    = 2,
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_WIDTH-1:0]   gray_in,
    input  logic                  load,
    output logic                  busy,
    output logic [IN_WIDTH-1:0]   bin_out,
    output logic [NUM_DIGITS-1:0] anodo,
    output logic [6:0]            catodo
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (!digits_fit(IN_WIDTH, NUM_DIGITS) || REFRESH_DIV < 1) begin : g_param_check
        $error("gray_display_mux: NUM_DIGITS too small for IN_WIDTH, or REFRESH_DIV < 1");
    end

    logic [IN_WIDTH-1:0]   bin_c;
    logic                  conv_busy;
    logic                  conv_done;
    logic [BCD_W-1:0]      conv_bcd;

    logic [IN_WIDTH-1:0]   bin_out_q, bin_out_d;
    logic [BCD_W-1:0]      digits_q, digits_d;
    logic [REF_W-1:0]      refresh_q, refresh_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic [NUM_DIGITS-1:0] anodo_q, anodo_d;
    logic [6:0]            catodo_q, catodo_d;
    logic [NUM_DIGITS-1:0] blank_c;
    logic                  zero_run_c;
    logic [3:0]            sel_digit_c;
    logic                  sel_blank_c;

    assign bin_c = IN_WIDTH'(gray_to_bin(32'(gray_in)));

    bin_a_bcd #(
        .IN_WIDTH   (IN_WIDTH),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (load),
        .bin_in  (bin_c),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd_out (conv_bcd)
    );

    always_comb begin
        bin_out_d = bin_out_q;
        digits_d  = digits_q;
        refresh_d = refresh_q + REF_W'(1);
        index_d   = index_q;
        if (load && !conv_busy) bin_out_d = bin_c;
        // Digits swap in whole at DONE so a partial conversion is never shown.
        if (conv_done) digits_d = conv_bcd;
        if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            index_d   = (index_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : index_q + IDX_W'(1);
        end

        // A digit is blanked when it and every more significant digit are zero.
        blank_c    = '0;
        zero_run_c = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            zero_run_c = zero_run_c & (digits_q[4*k +: 4] == 4'd0);
            blank_c[k] = (BLANK_LEADING != 0) && (k != 0) && zero_run_c;
        end

        sel_digit_c = 4'd0;
        sel_blank_c = 1'b0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (index_q == IDX_W'(k)) begin
                sel_digit_c = digits_q[4*k +: 4];
                sel_blank_c = blank_c[k];
            end
        end
        catodo_d = sel_blank_c ? SEG_BLANK : seg_decode(sel_digit_c);
        anodo_d  = ~(NUM_DIGITS'(1) << index_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_out_q <= '0;
            digits_q  <= '0;
            refresh_q <= '0;
            index_q   <= '0;
            anodo_q   <= ~NUM_DIGITS'(1);
            catodo_q  <= SEG_0;
        end else begin
            bin_out_q <= bin_out_d;
            digits_q  <= digits_d;
            refresh_q <= refresh_d;
            index_q   <= index_d;
            anodo_q   <= anodo_d;
            catodo_q  <= catodo_d;
        end
    end

    assign busy    = conv_busy;
    assign bin_out = bin_out_q;
    assign anodo   = anodo_q;
    assign catodo  = catodo_q;

endmodule

// File: tb/tb_gray_display_mux.sv
// Bench for gray_display_mux: three configurations checked against a decimal/segment reference model.
module tb_gray_display_mux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] gray_a;
    logic       load_a;
    logic [7:0] gray_c;
    logic       load_c;

    logic       busy_a, busy_b, busy_c;
    logic [3:0] bin_out_a, bin_out_b;
    logic [7:0] bin_out_c;
    logic [1:0] anodo_a, anodo_b;
    logic [2:0] anodo_c;
    logic [6:0] catodo_a, catodo_b, catodo_c;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    gray_display_mux #(.IN_WIDTH(4), .NUM_DIGITS(2), .REFRESH_DIV(4), .BLANK_LEADING(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_a), .load(load_a),
        .busy(busy_a), .bin_out(bin_out_a), .anodo(anodo_a), .catodo(catodo_a));

    gray_display_mux #(.IN_WIDTH(4), .NUM_DIGITS(2), .REFRESH_DIV(4), .BLANK_LEADING(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_a), .load(load_a),
        .busy(busy_b), .bin_out(bin_out_b), .anodo(anodo_b), .catodo(catodo_b));

    gray_display_mux #(.IN_WIDTH(8), .NUM_DIGITS(3), .REFRESH_DIV(1), .BLANK_LEADING(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_c), .load(load_c),
        .busy(busy_c), .bin_out(bin_out_c), .anodo(anodo_c), .catodo(catodo_c));

    // Reference model: plain decimal arithmetic and a segment lookup.
    function automatic int ref_g2b(input int g, input int w);
        int r = 0;
        for (int i = 0; i < w; i++) begin
            if (($countones(g >> i) % 2) == 1) r = r | (1 << i);
        end
        return r;
    endfunction

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
            3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
            9: return 7'b0000100;  default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] ref_digit_seg(input int v, input int k, input bit bl);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (bl && k > 0 && v < p) return 7'b1111111;
        return ref_seg((v / p) % 10);
    endfunction

    // Wait (bounded) until the selected DUT enables digit k, then return its segments.
    task automatic wait_seg(input int sel, input int k, output logic [6:0] seg, output bit ok);
        logic [2:0] an;
        logic [2:0] want;
        ok   = 1'b0;
        seg  = 7'bx;
        want = ~(3'b001 << k);
        @(negedge clk);
        for (int t = 0; t < 40 && !ok; t++) begin
            case (sel)
                0:       begin an = {1'b1, anodo_a}; seg = catodo_a; end
                1:       begin an = {1'b1, anodo_b}; seg = catodo_b; end
                default: begin an = anodo_c;         seg = catodo_c; end
            endcase
            if (an == want) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 50 && (busy_a || busy_c); t++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        gray_a = '0; load_a = 1'b0;
        gray_c = '0; load_c = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tests_run++;
        if (anodo_a !== 2'b10 || catodo_a !== 7'b0000001 || busy_a !== 1'b0 || bin_out_a !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_a: anodo=%b catodo=%b busy=%b bin_out=%0d, need 10 0000001 0 0",
                     anodo_a, catodo_a, busy_a, bin_out_a);
        end
        tests_run++;
        if (anodo_c !== 3'b110 || catodo_c !== 7'b0000001 || busy_c !== 1'b0 || bin_out_c !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_c: anodo=%b catodo=%b busy=%b bin_out=%0d, need 110 0000001 0 0",
                     anodo_c, catodo_c, busy_c, bin_out_c);
        end
    endtask

    // Called right after reset release; anodo shows the digit index of the previous cycle.
    task automatic test_scan();
        int m;
        logic [1:0] exp_a;
        logic [2:0] exp_c;
        for (int n = 0; n < 24; n++) begin
            m     = (n == 0) ? 0 : n - 1;
            exp_a = ~(2'b01 << ((m / 4) % 2));
            exp_c = ~(3'b001 << (m % 3));
            tests_run++;
            if (anodo_a !== exp_a || anodo_c !== exp_c) begin
                tests_failed++;
                $display("FAIL scan[%0d]: anodo_a=%b anodo_c=%b, need %b %b", n, anodo_a, anodo_c, exp_a, exp_c);
            end
            if (n == 5) begin gray_a = 4'b0110; load_a = 1'b1; end
            if (n == 6) load_a = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_load(input logic [3:0] g);
        int v;
        int cyc;
        logic [6:0] seg;
        bit ok;
        v = ref_g2b(int'(g), 4);
        wait_idle();
        gray_a = g; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        gray_a = 4'($urandom);
        cyc = 0;
        while (busy_a && cyc < 50) begin cyc++; @(negedge clk); end
        tests_run++;
        if (cyc != 5) begin
            tests_failed++;
            $display("FAIL busy_len_a g=%b: %0d cycles, need 5", g, cyc);
        end
        tests_run++;
        if (int'(bin_out_a) != v || int'(bin_out_b) != v) begin
            tests_failed++;
            $display("FAIL bin_out g=%b: a=%0d b=%0d, need %0d", g, bin_out_a, bin_out_b, v);
        end
        for (int k = 0; k < 2; k++) begin
            wait_seg(0, k, seg, ok);
            tests_run++;
            if (!ok || seg !== ref_digit_seg(v, k, 1'b1)) begin
                tests_failed++;
                $display("FAIL digit_a v=%0d k=%0d: seg=%b ok=%0d, need %b", v, k, seg, ok, ref_digit_seg(v, k, 1'b1));
            end
            wait_seg(1, k, seg, ok);
            tests_run++;
            if (!ok || seg !== ref_digit_seg(v, k, 1'b0)) begin
                tests_failed++;
                $display("FAIL digit_b v=%0d k=%0d: seg=%b ok=%0d, need %b", v, k, seg, ok, ref_digit_seg(v, k, 1'b0));
            end
        end
    endtask

    // Loads during SHIFT and in the DONE cycle are dropped; the cycle after DONE is accepted.
    task automatic test_busy_drop(input logic [3:0] x, input logic [3:0] y);
        int vx;
        int vy;
        logic [6:0] seg;
        bit ok;
        vx = ref_g2b(int'(x), 4);
        vy = ref_g2b(int'(y), 4);
        wait_idle();
        gray_a = x; load_a = 1'b1;
        @(negedge clk);
        gray_a = y; load_a = 1'b0;
        @(negedge clk);
        load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (busy_a !== 1'b1 || int'(bin_out_a) != vx) begin
            tests_failed++;
            $display("FAIL load_in_busy: busy=%b bin_out=%0d, need 1 %0d", busy_a, bin_out_a, vx);
        end
        load_a = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy_a !== 1'b0 || int'(bin_out_a) != vx) begin
            tests_failed++;
            $display("FAIL load_at_done: busy=%b bin_out=%0d, need 0 %0d", busy_a, bin_out_a, vx);
        end
        @(negedge clk);
        load_a = 1'b0;
        tests_run++;
        if (busy_a !== 1'b1 || int'(bin_out_a) != vy) begin
            tests_failed++;
            $display("FAIL load_after_done: busy=%b bin_out=%0d, need 1 %0d", busy_a, bin_out_a, vy);
        end
        wait_idle();
        for (int k = 0; k < 2; k++) begin
            wait_seg(0, k, seg, ok);
            tests_run++;
            if (!ok || seg !== ref_digit_seg(vy, k, 1'b1)) begin
                tests_failed++;
                $display("FAIL drop_digit k=%0d: seg=%b ok=%0d, need %b", k, seg, ok, ref_digit_seg(vy, k, 1'b1));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] seg;
        bit ok;
        wait_idle();
        gray_a = 4'b1000; load_a = 1'b1;
        gray_c = 8'b1000_0000; load_c = 1'b1;
        @(negedge clk);
        load_a = 1'b0; load_c = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy_a !== 1'b0 || bin_out_a !== 4'd0 || catodo_a !== 7'b0000001 || anodo_a !== 2'b10 ||
            busy_c !== 1'b0 || bin_out_c !== 8'd0 || catodo_c !== 7'b0000001) begin
            tests_failed++;
            $display("FAIL reset_mid: busy=%b bin=%0d cat=%b an=%b busy_c=%b bin_c=%0d cat_c=%b, need 0 0 0000001 10 0 0 0000001",
                     busy_a, bin_out_a, catodo_a, anodo_a, busy_c, bin_out_c, catodo_c);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        tests_run++;
        if (busy_a !== 1'b0 || bin_out_a !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_resume: busy=%b bin_out=%0d, need 0 0", busy_a, bin_out_a);
        end
        for (int k = 0; k < 2; k++) begin
            wait_seg(0, k, seg, ok);
            tests_run++;
            if (!ok || seg !== ref_digit_seg(0, k, 1'b1)) begin
                tests_failed++;
                $display("FAIL reset_mid_digit_a k=%0d: seg=%b ok=%0d, need %b", k, seg, ok, ref_digit_seg(0, k, 1'b1));
            end
            wait_seg(1, k, seg, ok);
            tests_run++;
            if (!ok || seg !== 7'b0000001) begin
                tests_failed++;
                $display("FAIL reset_mid_digit_b k=%0d: seg=%b ok=%0d, need 0000001", k, seg, ok);
            end
        end
    endtask

    task automatic test_wide(input logic [7:0] g);
        int v;
        int cyc;
        logic [6:0] seg;
        bit ok;
        v = ref_g2b(int'(g), 8);
        wait_idle();
        gray_c = g; load_c = 1'b1;
        @(negedge clk);
        load_c = 1'b0;
        gray_c = 8'($urandom);
        cyc = 0;
        while (busy_c && cyc < 50) begin cyc++; @(negedge clk); end
        tests_run++;
        if (cyc != 9 || int'(bin_out_c) != v) begin
            tests_failed++;
            $display("FAIL wide g=%b: busy %0d cycles bin_out=%0d, need 9 %0d", g, cyc, bin_out_c, v);
        end
        for (int k = 0; k < 3; k++) begin
            wait_seg(2, k, seg, ok);
            tests_run++;
            if (!ok || seg !== ref_digit_seg(v, k, 1'b1)) begin
                tests_failed++;
                $display("FAIL wide_digit v=%0d k=%0d: seg=%b ok=%0d, need %b", v, k, seg, ok, ref_digit_seg(v, k, 1'b1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load(4'b1000);
        test_load(4'b1101);
        test_load(4'b0000);
        test_busy_drop(4'b1000, 4'b1101);
        test_reset_mid();
        test_wide(8'b1000_0000);
        test_wide(8'b0000_0000);
        test_wide(8'b0000_0111);
        for (int i = 0; i < 8; i++) test_load(4'($urandom));
        for (int i = 0; i < 8; i++) test_wide(8'($urandom));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
